ifetch_queue: RTL

Instruction fetch queue sitting between the instruction-memory read port and the dual-issue decode stage. Each cycle it accepts one 64-bit fetched word carrying two 32-bit instructions and buffers them in a circular queue with their PCs. It presents the two oldest instructions to decode slots 0 and 1, and retires 0, 1 or 2 entries per cycle as decode reports what it issued. A flush input empties the queue on redirect or halt.

---
 rtl/ifq_pkg.sv | 20 ++
 rtl/ifq_ram.sv | 37 +++
 rtl/ifetch_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Instructions and PCs use big-endian bit numbering (bit 0 is the MSB).
package ifq_pkg;

   localparam int IFQ_DEPTH_DEFAULT = 16;
   localparam int IFQ_PC_W          = 64;
   localparam int INST_BYTES        = 4;

   typedef logic [0:31] inst_t;

   typedef struct packed {
      inst_t                inst;
      logic [0:IFQ_PC_W-1]  pc;
   } ifq_entry_t;

   function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ifq_ram.sv
// Queue storage: DEPTH entries, two write ports and two combinational read ports.
// Contents are deliberately not reset; validity is tracked by the pointers in ifetch_queue.
module ifq_ram
   import ifq_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wrEn0,
   input  logic [PTR_W-1:0] wrAddr0,
   input  ifq_entry_t       wrData0,
   input  logic             wrEn1,
   input  logic [PTR_W-1:0] wrAddr1,
   input  ifq_entry_t       wrData1,
   input  logic [PTR_W-1:0] rdAddr0,
   output ifq_entry_t       rdData0,
   input  logic [PTR_W-1:0] rdAddr1,
   output ifq_entry_t       rdData1
);

   ifq_entry_t mem [DEPTH];

   // The two write addresses are always consecutive entries, so they never collide.
   always_ff @(posedge clk) begin
      if (wrEn0) begin
         mem[wrAddr0] <= wrData0;
      end
      if (wrEn1) begin
         mem[wrAddr1] <= wrData1;
      end
   end

   assign rdData0 = mem[rdAddr0];
   assign rdData1 = mem[rdAddr1];

endmodule

// File: rtl/ifetch_queue.sv
// Circular instruction fetch queue feeding a dual-issue decoder.
// Optional feature: define IFQ_BYPASS_EN to forward fetched instructions straight to out0/out1 when empty.
module ifetch_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT,
   parameter int PC_W  = IFQ_PC_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fetch_valid,
   input  logic [0:63]             fetch_word,
   input  logic [0:PC_W-1]         fetch_pc,
   output logic                    fetch_ready,
   input  logic                    flush,
   input  logic [1:0]              deq_count,
   output logic                    out0_valid,
   output logic [0:31]             out0_inst,
   output logic [0:PC_W-1]         out0_pc,
   output logic                    out1_valid,
   output logic [0:31]             out1_inst,
   output logic [0:PC_W-1]         out1_pc,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] headNext;
   logic [PTR_W-1:0] tailNext;
   logic [CNT_W-1:0] countNext;

   ifq_entry_t rdEntry0;
   ifq_entry_t rdEntry1;
   ifq_entry_t wrEntry0;
   ifq_entry_t wrEntry1;
   logic       wrEn0;
   logic       wrEn1;

   inst_t           candInst0;
   inst_t           candInst1;
   logic [0:PC_W-1] candPc0;
   logic [0:PC_W-1] candPc1;
   logic [1:0]      candN;
   logic            misaligned;
   logic            fetchAccept;
   logic            bypassActive;

   logic [1:0] storedValid;
   logic [1:0] outValidN;
   logic [1:0] deqN;
   logic [1:0] skipN;
   logic [1:0] wrN;
   logic [1:0] headAdvance;

   inst_t           slotInst0;
   inst_t           slotInst1;
   logic [0:PC_W-1] slotPc0;
   logic [0:PC_W-1] slotPc1;

   ifq_ram #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) ram (
      .clk     (clk),
      .wrEn0   (wrEn0),
      .wrAddr0 (tail),
      .wrData0 (wrEntry0),
      .wrEn1   (wrEn1),
      .wrAddr1 (tail + PTR_W'(1)),
      .wrData1 (wrEntry1),
      .rdAddr0 (head),
      .rdData0 (rdEntry0),
      .rdAddr1 (head + PTR_W'(1)),
      .rdData1 (rdEntry1)
   );

   // Split the fetched word into its useful instructions, oldest first.
   always_comb begin
      misaligned = fetch_pc[PC_W-3];
      candInst1  = fetch_word[32:63];
      candPc0    = fetch_pc;
      candPc1    = fetch_pc + PC_W'(INST_BYTES);
      if (misaligned) begin
         candInst0 = fetch_word[32:63];
         candN     = 2'd1;
      end else begin
         candInst0 = fetch_word[0:31];
         candN     = 2'd2;
      end
   end

   assign fetch_ready = (count <= CNT_W'(DEPTH - 2));
   assign fetchAccept = fetch_valid & fetch_ready & ~flush;
   assign storedValid = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];

`ifdef IFQ_BYPASS_EN
   assign bypassActive = (count == '0) & fetch_valid & ~flush;
`else
   assign bypassActive = 1'b0;
`endif

   // Decode may ask for more than is visible; clamp to what the slots actually show.
   always_comb begin
      outValidN   = bypassActive ? candN : storedValid;
      deqN        = min2(deq_count, outValidN);
      skipN       = bypassActive ? deqN : 2'd0;
      headAdvance = bypassActive ? 2'd0 : deqN;
      wrN         = fetchAccept ? (candN - skipN) : 2'd0;
   end

   // Bypassed instructions already consumed this cycle are skipped; the rest go to storage.
   always_comb begin
      wrEn0         = (wrN != 2'd0);
      wrEn1         = (wrN == 2'd2);
      wrEntry0.inst = (skipN == 2'd1) ? candInst1 : candInst0;
      wrEntry0.pc   = IFQ_PC_W'((skipN == 2'd1) ? candPc1 : candPc0);
      wrEntry1.inst = candInst1;
      wrEntry1.pc   = IFQ_PC_W'(candPc1);
   end

   always_comb begin
      headNext  = head + PTR_W'(headAdvance);
      tailNext  = tail + PTR_W'(wrN);
      countNext = count + CNT_W'(wrN) - CNT_W'(headAdvance);
   end

   // Pointer and occupancy state; flush wins over any enqueue or dequeue in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= headNext;
         tail  <= tailNext;
         count <= countNext;
      end
   end

   always_comb begin
      if (bypassActive) begin
         slotInst0 = candInst0;
         slotPc0   = candPc0;
         slotInst1 = candInst1;
         slotPc1   = candPc1;
      end else begin
         slotInst0 = rdEntry0.inst;
         slotPc0   = PC_W'(rdEntry0.pc);
         slotInst1 = rdEntry1.inst;
         slotPc1   = PC_W'(rdEntry1.pc);
      end
   end

   // Invalid slots are forced to zero so decode never sees stale storage.
   always_comb begin
      out0_valid = (outValidN != 2'd0);
      out1_valid = (outValidN == 2'd2);
      out0_inst  = out0_valid ? slotInst0 : '0;
      out0_pc    = out0_valid ? slotPc0   : '0;
      out1_inst  = out1_valid ? slotInst1 : '0;
      out1_pc    = out1_valid ? slotPc1   : '0;
   end

endmodule
